// File: rtl/ip_periph_pkg.sv
// ip_periph shared definitions: register offsets, channel stride and the
// address-to-channel decode used by the top-level register file.
package ip_periph_pkg;

  localparam logic [3:0]  OFS_DATA  = 4'h0;
  localparam logic [3:0]  OFS_EVENT = 4'h4;
  localparam logic [3:0]  OFS_IRQEN = 4'h8;
  localparam logic [15:0] CH_STRIDE = 16'h0010;
  localparam int          STRIDE_SH = $clog2(CH_STRIDE);

  // Decoded access: channel index and byte offset inside the channel window
  typedef struct packed {
    logic [15:0] idx;
    logic [3:0]  ofs;
  } ch_sel_t;

  // Addresses below base wrap to a huge index, so they never match a channel
  function automatic ch_sel_t ch_decode(input logic [15:0] addr, input logic [15:0] base);
    logic [15:0] rel;
    ch_sel_t     sel;
    rel     = addr - base;
    sel.idx = rel >> STRIDE_SH;
    sel.ofs = rel[3:0];
    return sel;
  endfunction

endpackage

// File: rtl/ip_periph_debounce.sv
// ip_debounce: one input channel -- 2-flop synchroniser, stability counter
// and the debounced DATA word. o_chg flags the bits DATA flips this cycle.
module ip_debounce
  import ip_periph_pkg::*;
#(
  parameter int CH_W    = 32,
  parameter int DEB_CYC = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [CH_W-1:0] i_raw,
  output logic [CH_W-1:0] o_data,
  output logic [CH_W-1:0] o_chg
);

  localparam int CNT_W = $clog2(DEB_CYC + 1);

  logic [CH_W-1:0]  meta_reg, sync_reg, prev_reg;
  logic [CH_W-1:0]  data_reg, data_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Synchroniser chain, previous-cycle copy, counter and DATA
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      meta_reg <= '0;
      sync_reg <= '0;
      prev_reg <= '0;
      cnt_reg  <= '0;
      data_reg <= '0;
    end else begin
      meta_reg <= i_raw;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
      cnt_reg  <= cnt_next;
      data_reg <= data_next;
    end
  end

  // Count consecutive stable cycles of a word that differs from DATA; commit it
  // once the window is full. Any wobble or a match with DATA restarts the count.
  always_comb begin
    cnt_next  = cnt_reg;
    data_next = data_reg;
    if ((sync_reg != prev_reg) || (sync_reg == data_reg)) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_W'(DEB_CYC - 1)) begin
      data_next = sync_reg;
      cnt_next  = '0;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  assign o_data = data_reg;
  assign o_chg  = data_next ^ data_reg;

endmodule

// File: rtl/ip_periph.sv
// ip_periph: NUM_CH debounced input channels with per-channel DATA, sticky
// EVENT (write-1-to-clear) and IRQ_EN registers, plus a registered interrupt.
module ip_periph
  import ip_periph_pkg::*;
#(
  parameter int          NUM_CH    = 2,
  parameter int          CH_W      = 32,
  parameter logic [15:0] BASE_ADDR = 16'h7800,
  parameter int          DEB_CYC   = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_CH*CH_W-1:0] i_io_in,
  input  logic [15:0]            i_ip_addr,
  input  logic                   i_ip_wr,
  input  logic [31:0]            i_ip_wdata,
  output logic [31:0]            o_ip_data,
  output logic                   o_irq
);

  ch_sel_t              sel;
  logic                 ch_ok;
  logic [NUM_CH*32-1:0] rd_bus;
  logic [NUM_CH-1:0]    irq_ch;
  logic                 irq_reg, irq_next;

  assign sel   = ch_decode(i_ip_addr, BASE_ADDR);
  assign ch_ok = (sel.idx < 16'(NUM_CH));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic            hit;
      logic [CH_W-1:0] data_w, chg_w, clr_w;
      logic [CH_W-1:0] event_reg, event_next;
      logic [CH_W-1:0] irqen_reg, irqen_next;
      logic [31:0]     rd_word;

      assign hit = ch_ok && (sel.idx == 16'(gi));

      ip_debounce #(
        .CH_W    (CH_W),
        .DEB_CYC (DEB_CYC)
      ) u_deb (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_raw  (i_io_in[gi*CH_W +: CH_W]),
        .o_data (data_w),
        .o_chg  (chg_w)
      );

      // Register writes; a DATA change setting an EVENT bit beats a same-cycle clear
      always_comb begin
        clr_w      = '0;
        irqen_next = irqen_reg;
        if (i_ip_wr && hit && (sel.ofs == OFS_EVENT)) clr_w = i_ip_wdata[CH_W-1:0];
        if (i_ip_wr && hit && (sel.ofs == OFS_IRQEN)) irqen_next = i_ip_wdata[CH_W-1:0];
        event_next = (event_reg & ~clr_w) | chg_w;
      end

      // EVENT and IRQ_EN state
      always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
          event_reg <= '0;
          irqen_reg <= '0;
        end else begin
          event_reg <= event_next;
          irqen_reg <= irqen_next;
        end
      end

      // Read word for this channel, zero-extended; zero when not addressed
      always_comb begin
        rd_word = '0;
        if (hit) begin
          case (sel.ofs)
            OFS_DATA:  rd_word[CH_W-1:0] = data_w;
            OFS_EVENT: rd_word[CH_W-1:0] = event_reg;
            OFS_IRQEN: rd_word[CH_W-1:0] = irqen_reg;
            default:   rd_word = '0;
          endcase
        end
      end

      assign rd_bus[gi*32 +: 32] = rd_word;
      assign irq_ch[gi]          = |(event_reg & irqen_reg);
    end
  endgenerate

  // At most one channel drives a non-zero word, so OR-combine them
  always_comb begin
    o_ip_data = '0;
    for (int k = 0; k < NUM_CH; k++) o_ip_data = o_ip_data | rd_bus[k*32 +: 32];
  end

  assign irq_next = |irq_ch;

  // Interrupt output is registered
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) irq_reg <= 1'b0;
    else        irq_reg <= irq_next;
  end

  assign o_irq = irq_reg;

endmodule
